phase_ramp_gen_v2: RTL and testbench

Parametrised next-generation serrodyne phase-ramp generator for the closed-loop FOG feedback path.
- On each modulation step trigger, accumulates a signed feedback step into a ladder.
- Wraps the ladder modulo a runtime V2pi, in either unipolar or bipolar range.
- Adds the square-wave modulation with saturation to form the DAC word.
- Counts net 2π resets as a coarse angle/rate output.
- Sits between the loop filter (step source) and the modulation DAC, driven by the stepTrig of modulation_gen_v2.

---
 rtl/phase_ramp_pkg.sv | 13 +
 rtl/phase_wrap_acc.sv | 74 +++++++
 rtl/phase_ramp_gen_v2.sv | 44 ++++
 tb/tb_phase_ramp_gen_v2.sv | 109 ++++++++++
 4 files changed

// File: rtl/phase_ramp_pkg.sv
// phase_ramp_pkg: shared mode/wrap-direction codes and the signed saturating narrow helper
package phase_ramp_pkg;
  localparam logic MODE_UNIPOLAR = 1'b0;
  localparam logic MODE_BIPOLAR  = 1'b1;
  localparam logic WRAP_UP       = 1'b1;
  localparam logic WRAP_DOWN     = 1'b0;
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return x > mx ? mx : x < mn ? mn : x;
  endfunction
endpackage

// File: rtl/phase_wrap_acc.sv
// phase_wrap_acc: trigger-sampled shadows, clamped step accumulate, modulo-V2pi wrap and net wrap counter (in: clk/rst_n/trig/step/v2pi/fb_on/mode; out: ladder/wrap/wrap_dir/wrap_cnt)
module phase_wrap_acc import phase_ramp_pkg::*; #(
  parameter int OUTPUT_BIT  = 16,
  parameter int ACC_BIT     = 32,
  parameter int WRAPCNT_BIT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_trig,
  input  logic signed [31:0]            i_step,
  input  logic [31:0]                   i_v2pi,
  input  logic                          i_fb_on,
  input  logic                          i_mode,
  output logic signed [OUTPUT_BIT-1:0]  o_ladder,
  output logic                          o_wrap,
  output logic                          o_wrap_dir,
  output logic signed [WRAPCNT_BIT-1:0] o_wrap_cnt
);
  localparam logic signed [WRAPCNT_BIT-1:0] CMAX = {1'b0, {(WRAPCNT_BIT-1){1'b1}}};
  localparam logic signed [WRAPCNT_BIT-1:0] CMIN = {1'b1, {(WRAPCNT_BIT-1){1'b0}}};
  logic signed [31:0] step_q, step_d;
  logic [31:0] v2pi_q, v2pi_d;
  logic mode_q, mode_d;
  logic signed [ACC_BIT-1:0] acc_q, acc_d;
  logic wrap_q, wrap_d, dir_q, dir_d;
  logic signed [WRAPCNT_BIT-1:0] cnt_q, cnt_d;
  logic signed [63:0] v, half, vm1, step_w, step_eff, sum, lo, hi, nxt;
  logic up, dn, upd;
  always_comb begin
    step_d = i_trig ? i_step : step_q;
    v2pi_d = i_trig ? i_v2pi : v2pi_q;
    mode_d = i_trig ? i_mode : mode_q;
    v = {32'd0, v2pi_d};
    half = v >>> 1;
    vm1 = v - 64'sd1;
    step_w = 64'(step_d);
    step_eff = step_w > vm1 ? vm1 : step_w < -vm1 ? -vm1 : step_w;
    sum = 64'(acc_q) + step_eff;
    lo = mode_d == MODE_BIPOLAR ? -half : 64'sd0;
    hi = mode_d == MODE_BIPOLAR ? v - half : v;
    up = sum >= hi;
    dn = sum < lo;
    nxt = up ? sum - v : dn ? sum + v : sum;
    upd = i_trig && i_fb_on && v != 64'sd0;
    acc_d = !i_fb_on || (i_trig && v == 64'sd0) ? '0 : upd ? ACC_BIT'(nxt) : acc_q;
    wrap_d = upd && (up || dn);
    dir_d = wrap_d ? (up ? WRAP_UP : WRAP_DOWN) : dir_q;
    cnt_d = wrap_d && up && cnt_q != CMAX ? cnt_q + WRAPCNT_BIT'(1) :
            wrap_d && dn && cnt_q != CMIN ? cnt_q - WRAPCNT_BIT'(1) : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_q <= '0;
      v2pi_q <= '0;
      mode_q <= '0;
      acc_q  <= '0;
      wrap_q <= '0;
      dir_q  <= '0;
      cnt_q  <= '0;
    end else begin
      step_q <= step_d;
      v2pi_q <= v2pi_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
    end
  end
  assign o_ladder   = acc_q[OUTPUT_BIT-1:0];
  assign o_wrap     = wrap_q;
  assign o_wrap_dir = dir_q;
  assign o_wrap_cnt = cnt_q;
endmodule

// File: rtl/phase_ramp_gen_v2.sv
// phase_ramp_gen_v2: serrodyne ladder plus saturated modulation DAC word (in: clk/rst_n/trig/step/v2pi/fb_on/mode/mod; out: ladderWave/phaseRamp/mod/wrap/wrap_dir/wrap_cnt)
module phase_ramp_gen_v2 import phase_ramp_pkg::*; #(
  parameter int OUTPUT_BIT  = 16,
  parameter int ACC_BIT     = 32,
  parameter int WRAPCNT_BIT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_trig,
  input  logic signed [31:0]            i_step,
  input  logic [31:0]                   i_v2pi,
  input  logic                          i_fb_on,
  input  logic                          i_mode,
  input  logic signed [OUTPUT_BIT-1:0]  i_mod,
  output logic signed [OUTPUT_BIT-1:0]  o_ladderWave,
  output logic signed [OUTPUT_BIT-1:0]  o_phaseRamp,
  output logic signed [OUTPUT_BIT-1:0]  o_mod,
  output logic                          o_wrap,
  output logic                          o_wrap_dir,
  output logic signed [WRAPCNT_BIT-1:0] o_wrap_cnt
);
  logic signed [OUTPUT_BIT-1:0] ladder, pr_q, pr_d, mod_q, mod_d;
  phase_wrap_acc #(.OUTPUT_BIT(OUTPUT_BIT), .ACC_BIT(ACC_BIT), .WRAPCNT_BIT(WRAPCNT_BIT)) u_acc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trig(i_trig), .i_step(i_step), .i_v2pi(i_v2pi),
    .i_fb_on(i_fb_on), .i_mode(i_mode), .o_ladder(ladder), .o_wrap(o_wrap),
    .o_wrap_dir(o_wrap_dir), .o_wrap_cnt(o_wrap_cnt)
  );
  always_comb begin
    pr_d  = OUTPUT_BIT'(sat_narrow(64'(ladder) + 64'(i_mod), OUTPUT_BIT));
    mod_d = i_mod;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pr_q  <= '0;
      mod_q <= '0;
    end else begin
      pr_q  <= pr_d;
      mod_q <= mod_d;
    end
  end
  assign o_ladderWave = ladder;
  assign o_phaseRamp  = pr_q;
  assign o_mod        = mod_q;
endmodule

// File: tb/tb_phase_ramp_gen_v2.sv
// tb_phase_ramp_gen_v2: directed self-checking bench for the phase ramp generator
module tb_phase_ramp_gen_v2;
  logic clk = 1'b0, rst_n, trig, fb_on, mode;
  logic signed [31:0] step;
  logic [31:0] v2pi;
  logic signed [15:0] mod, ladder, pr, omod, cnt;
  logic wrap, dir;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  phase_ramp_gen_v2 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_step(step), .i_v2pi(v2pi),
    .i_fb_on(fb_on), .i_mode(mode), .i_mod(mod), .o_ladderWave(ladder),
    .o_phaseRamp(pr), .o_mod(omod), .o_wrap(wrap), .o_wrap_dir(dir), .o_wrap_cnt(cnt)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  task automatic pulse();
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask
  task automatic clr();
    @(negedge clk);
    fb_on = 1'b0;
    @(negedge clk);
    fb_on = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; trig = 1'b0; step = 0; v2pi = 0; fb_on = 1'b0; mode = 1'b0; mod = 0;
    repeat (2) @(negedge clk);
    chk("rst_ladder", ladder, 0); chk("rst_pr", pr, 0); chk("rst_mod", omod, 0);
    chk("rst_wrap", wrap, 0); chk("rst_dir", dir, 0); chk("rst_cnt", cnt, 0);
    rst_n = 1'b1; fb_on = 1'b1; v2pi = 8000; step = 150;
    for (int k = 0; k < 53; k++) begin
      repeat (198) @(negedge clk);
      pulse();
    end
    chk("t1_ladder53", ladder, 7950); chk("t1_cnt53", cnt, 0);
    pulse();
    chk("t1_ladder54", ladder, 100); chk("t1_wrap", wrap, 1); chk("t1_dir", dir, 1); chk("t1_cnt", cnt, 1);
    @(negedge clk);
    chk("t1_wrap_low", wrap, 0); chk("t1_pr_lat2", pr, 100);
    clr();
    chk("t2_clr_ladder", ladder, 0); chk("t2_clr_cnt_held", cnt, 1);
    step = -100; pulse();
    chk("t2_ladder", ladder, 7900); chk("t2_wrap", wrap, 1); chk("t2_dir", dir, 0); chk("t2_cnt", cnt, 0);
    mod = 30000; @(negedge clk);
    chk("t4_pr_sat", pr, 32767); chk("t4_omod", omod, 30000);
    mod = 0; step = 150; pulse();
    chk("t2_up_ladder", ladder, 50); chk("t2_up_wrap", wrap, 1); chk("t2_up_dir", dir, 1); chk("t2_up_cnt", cnt, 1);
    pulse();
    chk("t2_ladder200", ladder, 200); chk("t2_nowrap", wrap, 0); chk("t2_cnt_same", cnt, 1);
    @(negedge clk);
    mod = -1000;
    chk("t4_pr_before", pr, 200);
    @(negedge clk);
    chk("t4_pr_after", pr, -800); chk("t4_omod_neg", omod, -1000);
    mod = 0;
    clr(); mode = 1'b1; step = 150;
    for (int k = 0; k < 26; k++) pulse();
    chk("t3_ladder26", ladder, 3900); chk("t3_cnt26", cnt, 1);
    pulse();
    chk("t3_ladder27", ladder, -3950); chk("t3_wrap", wrap, 1); chk("t3_dir", dir, 1); chk("t3_cnt", cnt, 2);
    step = -150; pulse();
    chk("t3_dn_ladder", ladder, 3900); chk("t3_dn_wrap", wrap, 1); chk("t3_dn_dir", dir, 0); chk("t3_dn_cnt", cnt, 1);
    clr(); mode = 1'b0; step = 9000; pulse();
    chk("t5_clamp_ladder", ladder, 7999); chk("t5_clamp_nowrap", wrap, 0); chk("t5_clamp_cnt", cnt, 1);
    pulse();
    chk("t5_ladder", ladder, 7998); chk("t5_wrap", wrap, 1); chk("t5_cnt", cnt, 2);
    step = -9000; pulse();
    chk("t5_neg_ladder", ladder, 7999); chk("t5_neg_dir", dir, 0); chk("t5_neg_cnt", cnt, 1);
    v2pi = 0; pulse();
    chk("v0_ladder", ladder, 0); chk("v0_nowrap", wrap, 0); chk("v0_cnt", cnt, 1);
    v2pi = 8000; step = 3000; pulse();
    chk("co_start", ladder, 3000);
    v2pi = 1000; step = 0; pulse();
    chk("co_1", ladder, 2000); chk("co_1_wrap", wrap, 1); chk("co_1_cnt", cnt, 2);
    pulse();
    chk("co_2", ladder, 1000); chk("co_2_cnt", cnt, 3);
    pulse();
    chk("co_3", ladder, 0); chk("co_3_cnt", cnt, 4);
    pulse();
    chk("co_4", ladder, 0); chk("co_4_nowrap", wrap, 0); chk("co_4_cnt", cnt, 4);
    v2pi = 8000; step = 3000; pulse();
    chk("t6_ladder", ladder, 3000);
    @(negedge clk);
    trig = 1'b1; fb_on = 1'b0;
    @(negedge clk);
    trig = 1'b0; fb_on = 1'b1;
    chk("t6_fboff_ladder", ladder, 0); chk("t6_fboff_wrap", wrap, 0); chk("t6_fboff_cnt", cnt, 4);
    pulse();
    mod = 123;
    repeat (2) @(negedge clk);
    chk("t6_pr_pre", pr, 3123); chk("t6_dir_pre", dir, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ladder", ladder, 0); chk("ar_pr", pr, 0); chk("ar_mod", omod, 0);
    chk("ar_cnt", cnt, 0); chk("ar_dir", dir, 0); chk("ar_wrap", wrap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
